// File: rtl/common_pkg.sv
// ==== common : shared fetch-side types and constants (rev 1.0) ====
`default_nettype none

package common;

  localparam logic [63:0] PCINIT = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_HOLD  = 2'd1,
    FS_FLUSH = 2'd2,
    FS_ERR   = 2'd3
  } fetch_state_t;

  function automatic logic pc_misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Where a fresh PC lands once no request is outstanding.
  function automatic fetch_state_t entry_state(input logic [63:0] addr);
    return pc_misaligned(addr) ? FS_ERR : FS_REQ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ==== fetch_ctrl : single-outstanding instruction fetch controller (rev 1.0) ====
`default_nettype none

module fetch_ctrl #(
  parameter logic [63:0] PCINIT = common::PCINIT
) (
  input  logic               clk,
  input  logic               reset,
  output common::ibus_req_t  ireq,
  input  common::ibus_resp_t iresp,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  input  logic               stall,
  output logic [63:0]        pc,
  output logic [31:0]        raw_instr,
  output logic               instr_valid,
  output logic               misalign
);

  common::fetch_state_t state, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        addr_sent_q, addr_sent_d;
  logic        req_valid;
  logic        accepted;

  // Gated by reset so the bus goes idle the instant reset asserts.
  assign req_valid = reset && (state == common::FS_REQ) && !addr_sent_q;
  // A request is outstanding once its address has been taken, including this cycle.
  assign accepted  = addr_sent_q || (req_valid && iresp.addr_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= common::FS_REQ;
      pc_q        <= PCINIT;
      instr_q     <= 32'h0;
      addr_sent_q <= 1'b0;
    end else begin
      state       <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      addr_sent_q <= addr_sent_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    instr_d     = instr_q;
    addr_sent_d = addr_sent_q;
    case (state)
      common::FS_REQ: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          addr_sent_d = 1'b0;
          if (accepted && !iresp.data_ok) begin
            state_d = common::FS_FLUSH;
          end else begin
            state_d = common::entry_state(redirect_pc);
          end
        end else if (accepted && iresp.data_ok) begin
          instr_d     = iresp.data;
          addr_sent_d = 1'b0;
          state_d     = common::FS_HOLD;
        end else if (req_valid && iresp.addr_ok) begin
          addr_sent_d = 1'b1;
        end
      end
      common::FS_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = common::entry_state(redirect_pc);
        end else if (!stall) begin
          pc_d    = pc_q + 64'd4;
          state_d = common::FS_REQ;
        end
      end
      common::FS_FLUSH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        // The stale response retires here; the freshest PC decides where to go.
        if (iresp.data_ok) begin
          addr_sent_d = 1'b0;
          state_d     = common::entry_state(redirect_valid ? redirect_pc : pc_q);
        end
      end
      common::FS_ERR: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = common::entry_state(redirect_pc);
        end
      end
      default: begin
        state_d = common::FS_REQ;
      end
    endcase
  end

  always_comb begin
    ireq.valid  = req_valid;
    ireq.addr   = pc_q;
    pc          = pc_q;
    instr_valid = (state == common::FS_HOLD) || (state == common::FS_ERR);
    raw_instr   = (state == common::FS_ERR) ? 32'h0 : instr_q;
    misalign    = common::pc_misaligned(pc_q);
  end

endmodule

`default_nettype wire
